// File: rtl/int_accum_pkg.sv
// int_accum_pkg
// Shared types and helpers for the integer vector accumulator.
//   accum_state_t : controller states (ACCUM collects beats, DRAIN presents the sum)
//   acc_width()   : accumulator width needed to sum 'beats' signed values of
//                   'in_w' bits without overflow
package int_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } accum_state_t;

    function automatic int acc_width(input int in_w, input int beats);
        return in_w + $clog2(beats);
    endfunction

endpackage

// File: rtl/int_accum_lane.sv
// int_accum_lane
// One element of the accumulator: a signed register that either loads or adds
// a sign-extended input sample.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset, clears the register
//   load    : replace the register with sign-extended din (has priority)
//   add_en  : add sign-extended din to the register
//   din     : signed input sample, IN_W bits
//   acc     : signed accumulator value, OUT_W bits
module int_accum_lane #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    add_en,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] acc
);

    logic signed [OUT_W-1:0] din_ext;

    // Size cast of a signed operand sign-extends.
    assign din_ext = OUT_W'(din);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= din_ext;
        end else if (add_en) begin
            acc <= acc + din_ext;
        end
    end

endmodule

// File: rtl/int_vector_accumulator.sv
// int_vector_accumulator
// Sums NUM_BEATS consecutive signed input arrays element by element and
// presents the full-precision sum on a valid/ready output.
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset, discards any partial/pending sum
//   data_in   : DIM signed elements of IN_WIDTH bits
//   valid_in  : data_in valid
//   ready_in  : block accepts data_in this cycle
//   data_out  : DIM signed accumulated elements of OUT_WIDTH bits
//   valid_out : data_out valid
//   ready_out : downstream accepts data_out
// Build option:
//   INT_VECTOR_ACCUMULATOR_OVERLAP_EN : in DRAIN, ready_in follows ready_out and
//   a beat accepted together with the output handshake starts the next sum.
//
// state | meaning
// ------+-----------------------------------------------------------
// ACCUM | collecting beats; ready_in = 1, valid_out = 0
// DRAIN | sum complete; valid_out = 1, data_out held until accepted
module int_vector_accumulator
    import int_accum_pkg::*;
#(
    parameter int  IN_WIDTH  = 16,
    parameter int  DIM       = 8,
    parameter int  NUM_BEATS = 4,
    localparam int OUT_WIDTH = acc_width(IN_WIDTH, NUM_BEATS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  data_in [DIM],
    input  logic                        valid_in,
    output logic                        ready_in,
    output logic signed [OUT_WIDTH-1:0] data_out [DIM],
    output logic                        valid_out,
    input  logic                        ready_out
);

    localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    accum_state_t     state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             in_hs, out_hs;
    logic             last_beat;
    logic             acc_load;

    assign last_beat = (count == LAST_BEAT);
    // count is 0 in DRAIN, so an overlapped beat also lands as a load.
    assign acc_load  = in_hs && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        ready_in  = 1'b0;
        valid_out = 1'b0;
        state_nxt = state;
        count_nxt = count;

        case (state)
            ACCUM: ready_in = 1'b1;
            DRAIN: begin
                valid_out = 1'b1;
`ifdef INT_VECTOR_ACCUMULATOR_OVERLAP_EN
                ready_in  = ready_out;
`else
                ready_in  = 1'b0;
`endif
            end
            default: ready_in = 1'b0;
        endcase

        in_hs  = valid_in && ready_in;
        out_hs = valid_out && ready_out;

        if (in_hs) begin
            count_nxt = last_beat ? '0 : count + CNT_W'(1);
        end

        case (state)
            ACCUM: begin
                if (in_hs && last_beat) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // With NUM_BEATS = 1 an overlapped beat completes a new sum at once.
                if (out_hs) begin
                    state_nxt = (in_hs && last_beat) ? DRAIN : ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        int_accum_lane #(
            .IN_W  (IN_WIDTH),
            .OUT_W (OUT_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load   (acc_load),
            .add_en (in_hs),
            .din    (data_in[i]),
            .acc    (data_out[i])
        );
    end

endmodule

// File: tb/tb_int_vector_accumulator.sv
module tb_int_vector_accumulator;

    localparam int IN_WIDTH  = 16;
    localparam int DIM       = 2;
    localparam int NUM_BEATS = 4;
    localparam int OUT_WIDTH = 18;

    logic                        clk = 1'b0;
    logic                        rst;
    logic signed [IN_WIDTH-1:0]  data_in [DIM];
    logic                        valid_in;
    logic                        ready_in;
    logic signed [OUT_WIDTH-1:0] data_out [DIM];
    logic                        valid_out;
    logic                        ready_out;

    int n_checks = 0;
    int n_fail   = 0;

    int_vector_accumulator #(
        .IN_WIDTH  (IN_WIDTH),
        .DIM       (DIM),
        .NUM_BEATS (NUM_BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int b, input logic v);
        data_in[0] = a[IN_WIDTH-1:0];
        data_in[1] = b[IN_WIDTH-1:0];
        valid_in   = v;
    endtask

    // Present one beat for one cycle; the DUT must be ready for it.
    task automatic send(input string tag, input int a, input int b);
        check_eq({tag, "_ready_in"}, int'(ready_in), 1);
        drive(a, b, 1'b1);
        step();
        valid_in = 1'b0;
    endtask

    task automatic check_out(input string tag, input int e0, input int e1);
        check_eq({tag, "_valid"}, int'(valid_out), 1);
        check_eq({tag, "_d0"}, int'(data_out[0]), e0);
        check_eq({tag, "_d1"}, int'(data_out[1]), e1);
    endtask

    initial begin
        rst       = 1'b1;
        ready_out = 1'b1;
        drive(0, 0, 1'b0);
        step();
        step();
        rst = 1'b0;

        check_eq("rst_valid_out", int'(valid_out), 0);
        check_eq("rst_ready_in", int'(ready_in), 1);
        check_eq("rst_d0", int'(data_out[0]), 0);
        check_eq("rst_d1", int'(data_out[1]), 0);

        // Basic sum on consecutive cycles
        for (int k = 1; k <= 4; k++) begin
            check_eq("basic_no_early_valid", int'(valid_out), 0);
            drive(k, -k, 1'b1);
            step();
        end
        valid_in = 1'b0;
        check_out("basic", 10, -10);
`ifdef INT_VECTOR_ACCUMULATOR_OVERLAP_EN
        check_eq("basic_drain_ready_in", int'(ready_in), 1);
`else
        check_eq("basic_drain_ready_in", int'(ready_in), 0);
`endif
        step();
        check_eq("basic_one_cycle", int'(valid_out), 0);
        check_eq("basic_back_accum", int'(ready_in), 1);

        // Extremes, no wrap at OUT_WIDTH
        for (int k = 0; k < 4; k++) send("neg", -32768, -32768);
        check_out("neg_ext", -131072, -131072);
        step();
        for (int k = 0; k < 4; k++) send("pos", 32767, 32767);
        check_out("pos_ext", 131068, 131068);
        step();
        check_eq("ext_done", int'(valid_out), 0);

        // Backpressure in DRAIN with extra valid_in offered
        ready_out = 1'b0;
        for (int k = 0; k < 4; k++) send("bp", 7, -1);
        for (int c = 0; c < 5; c++) begin
            check_out("bp_hold", 28, -4);
            check_eq("bp_ready_in", int'(ready_in), 0);
            drive(100, 100, 1'b1);
            step();
        end
        check_out("bp_still", 28, -4);
        valid_in  = 1'b0;
        ready_out = 1'b1;
        step();
        check_eq("bp_release", int'(valid_out), 0);
        check_eq("bp_ready_after", int'(ready_in), 1);

        // Gapped input: valid 1,0,0,1,1,0,1 with 5,x,x,6,7,x,8
        begin
            int gv [7] = '{1, 0, 0, 1, 1, 0, 1};
            int gd [7] = '{5, 99, 99, 6, 7, 99, 8};
            for (int c = 0; c < 7; c++) begin
                check_eq("gap_no_early_valid", int'(valid_out), 0);
                drive(gd[c], -gd[c], gv[c][0]);
                step();
            end
        end
        valid_in = 1'b0;
        check_out("gap", 26, -26);
        step();
        check_eq("gap_once", int'(valid_out), 0);
        step();
        check_eq("gap_once2", int'(valid_out), 0);

        // Reset after two beats discards the partial sum
        send("part", 50, 50);
        send("part", 50, 50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_valid", int'(valid_out), 0);
        check_eq("midrst_ready", int'(ready_in), 1);
        for (int k = 0; k < 3; k++) begin
            send("after_rst", 1, 1);
            check_eq("after_rst_no_valid", int'(valid_out), 0);
        end
        send("after_rst", 1, 1);
        check_out("after_rst", 4, 4);
        step();

`ifdef INT_VECTOR_ACCUMULATOR_OVERLAP_EN
        // Back-to-back sums with overlapped handshakes
        begin
            int exp_sum [3] = '{10, 26, 42};
            for (int k = 1; k <= 12; k++) begin
                check_eq("ovl_ready_in", int'(ready_in), 1);
                drive(k, -k, 1'b1);
                step();
                if (k % 4 == 0) begin
                    check_out("ovl", exp_sum[k/4-1], -exp_sum[k/4-1]);
                end else begin
                    check_eq("ovl_gap_valid", int'(valid_out), 0);
                end
            end
            valid_in = 1'b0;
            check_eq("ovl_last_ready", int'(ready_in), 1);
            step();
            check_eq("ovl_done", int'(valid_out), 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_vector_accumulator.md
Name: int_vector_accumulator

Overview:
Downstream consumer of the entrywise product stage. It accepts a stream of signed product arrays over a valid/ready handshake. It sums NUM_BEATS consecutive arrays element by element in registered accumulators, then presents the summed array on a valid/ready output. It is used to reduce a tiled dot product across time before requantisation.

Parameters:
IN_WIDTH, 16, width of each signed input element (= A_WIDTH + B_WIDTH of the upstream product stage)
DIM, 8, number of elements per array
NUM_BEATS, 4, number of input arrays summed per output; legal range 1 or more
OUT_WIDTH (localparam), IN_WIDTH + $clog2(NUM_BEATS), width of each accumulated output element; equals IN_WIDTH when NUM_BEATS = 1

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
data_in  input  signed [IN_WIDTH-1:0] x DIM  input array
valid_in  input  1  input array valid
ready_in  output  1  block can accept data_in this cycle
data_out  output  signed [OUT_WIDTH-1:0] x DIM  accumulated array
valid_out  output  1  data_out valid
ready_out  input  1  downstream accepts data_out

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state = ACCUM, beat counter = 0, accumulators = 0.
  - valid_out = 0, ready_in = 1 in the first cycle after reset, data_out = 0.
- States:
  - ACCUM: ready_in = 1, valid_out = 0.
  - DRAIN: ready_in = 0 (see Optional Feature), valid_out = 1, data_out = accumulators.
- Input handshake is valid_in && ready_in. Output handshake is valid_out && ready_out.
- In ACCUM, on an input handshake:
  - If count == 0: acc[i] <= sign-extended data_in[i]. There is no clear cycle.
  - Otherwise: acc[i] <= acc[i] + sign-extended data_in[i].
- Counter and transitions:
  - On an input handshake with count < NUM_BEATS-1: count increments.
  - On an input handshake with count == NUM_BEATS-1: count <= 0 and the state goes to DRAIN.
- In DRAIN:
  - On an output handshake, state goes to ACCUM.
  - Without an output handshake, data_out and valid_out hold stable (AXI-style: no retraction, no data change while stalled).
- valid_in low in ACCUM: no state change. Gaps between beats are legal.
- Latency: valid_out rises in the cycle after the NUM_BEATS-th input handshake.
- Throughput without the optional feature: NUM_BEATS+1 cycles per output minimum.
- Arithmetic: signed two's complement, full precision. OUT_WIDTH guarantees no overflow for NUM_BEATS inputs. No rounding, no saturation.
- NUM_BEATS = 1: each accepted input is registered and presented the next cycle. This behaves as a half-rate pipeline register.
- rst asserted mid-accumulation or in DRAIN discards the partial or pending sum. No output is produced for it.
- ready_in and valid_out are combinational decodes of registered state only. No combinational path exists from ready_out to ready_in unless the Optional Feature is enabled.

Optional Feature:
Macro INT_VECTOR_ACCUMULATOR_OVERLAP_EN.
- Defined:
  - In DRAIN, ready_in = ready_out.
  - An input handshake coinciding with the output handshake is treated as beat 0 of the next sum: acc loads data_in, count <= 1, state goes to ACCUM.
  - If NUM_BEATS = 1, the state instead stays in DRAIN with the new value.
  - Sustained throughput becomes one output per NUM_BEATS cycles.
  - This adds a combinational ready_out -> ready_in path.
- Undefined: behaviour exactly as above, with ready_in = 0 throughout DRAIN.

Decomposition:
- Package int_accum_pkg holds:
  - enum typedef accum_state_t {ACCUM, DRAIN};
  - function acc_width(in_w, beats) returning in_w + $clog2(beats).
- One natural sub-module: int_accum_lane, a single-element load/add register with load, add_en and signed widths as parameters. It is instantiated DIM times via generate.
- The FSM and counter stay in the top module.

Test Plan:
- DIM=2, NUM_BEATS=4, inputs {1,-1},{2,-2},{3,-3},{4,-4} on consecutive cycles, ready_out=1 -> valid_out for exactly 1 cycle, 1 cycle after the 4th handshake, data_out={10,-10}.
- Extremes: IN_WIDTH=16, all 4 beats = -32768 -> data_out = -131072 in OUT_WIDTH=18, no wrap. Then all beats = 32767 -> 131068.
- Backpressure: ready_out=0 for 5 cycles during DRAIN -> valid_out held, data_out stable, ready_in=0, extra valid_in ignored. Release -> one handshake, then back to ACCUM.
- Gapped input: valid_in toggling 1,0,0,1,1,0,1 with values 5,x,x,6,7,x,8 -> output {26} once. Zeros in gaps are not accumulated.
- Reset mid-operation: rst pulse after 2 of 4 beats, then 4 beats of 1 -> output 4, not 4 plus stale partial sum.
- With INT_VECTOR_ACCUMULATOR_OVERLAP_EN, continuous valid_in and ready_out=1, 12 beats of value k = 1..12 -> outputs 10, 26, 42 spaced exactly 4 cycles apart, ready_in never low.
